// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared widths, op-code and FSM encodings, and the
// single-cycle ALU evaluation used by the alu_exec execute stage.
package alu_exec_pkg;

   localparam int DATA_W = 8;
   localparam int IDX_W  = 3;
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_WB   = 2'b10
   } state_e;

   typedef struct packed {
      logic              cf;
      logic [DATA_W-1:0] data;
   } alu_res_t;

   // Single-cycle ALU result and carry/borrow. MUL is not handled here:
   // it goes through the sequential multiplier and yields zeros.
   function automatic alu_res_t alu_eval(input op_e op,
                                         input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
      alu_res_t          res;
      logic [DATA_W:0]   wide;
      wide     = 9'd0;
      res.cf   = 1'b0;
      res.data = 8'h00;
      case (op)
         OP_ADD: begin
            wide     = {1'b0, a} + {1'b0, b};
            res.cf   = wide[DATA_W];
            res.data = wide[DATA_W-1:0];
         end
         OP_SUB: begin
            // ninth bit of the 9-bit difference is the borrow (a < b)
            wide     = {1'b0, a} - {1'b0, b};
            res.cf   = wide[DATA_W];
            res.data = wide[DATA_W-1:0];
         end
         OP_AND:  res.data = a & b;
         OP_OR:   res.data = a | b;
         OP_XOR:  res.data = a ^ b;
         OP_SHL:  res.data = a << b[2:0];
         OP_SHR:  res.data = a >> b[2:0];
         default: begin
            res.cf   = 1'b0;
            res.data = 8'h00;
         end
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mul8_seq.sv
// mul8_seq: 8x8 unsigned shift-add multiplier, one multiplier bit per
// clock, LSB first. Present only when ALU_EXEC_MUL_EN is defined.
// 'product' shows the accumulator including the step being applied this
// cycle, so it is the final product while 'done' is high.
`ifdef ALU_EXEC_MUL_EN
module mul8_seq
   import alu_exec_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [2:0]        count,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   logic [PROD_W-1:0] mcand_r;
   logic [PROD_W-1:0] acc_r;
   logic [PROD_W-1:0] acc_next_s;
   logic [DATA_W-1:0] mplier_r;
   logic [2:0]        cnt_r;
   logic              run_r;

   // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
   always_comb begin
      acc_next_s = acc_r;
      if (mplier_r[0]) begin
         acc_next_s = acc_r + mcand_r;
      end else begin
         acc_next_s = acc_r;
      end
   end

   // Capture operands on start, then run eight iterations and stop
   always_ff @(posedge CLK) begin
      if (RST) begin
         mcand_r  <= 16'h0000;
         acc_r    <= 16'h0000;
         mplier_r <= 8'h00;
         cnt_r    <= 3'd0;
         run_r    <= 1'b0;
      end else if (start) begin
         mcand_r  <= {8'h00, a};
         acc_r    <= 16'h0000;
         mplier_r <= b;
         cnt_r    <= 3'd0;
         run_r    <= 1'b1;
      end else if (run_r) begin
         acc_r    <= acc_next_s;
         mcand_r  <= {mcand_r[PROD_W-2:0], 1'b0};
         mplier_r <= {1'b0, mplier_r[DATA_W-1:1]};
         cnt_r    <= cnt_r + 3'd1;
         if (cnt_r == 3'd7) begin
            run_r <= 1'b0;
         end else begin
            run_r <= 1'b1;
         end
      end
   end

   assign count   = cnt_r;
   assign done    = run_r & (cnt_r == 3'd7);
   assign product = acc_next_s;

endmodule
`endif

// File: rtl/alu_exec.sv
// alu_exec: execute stage feeding the register-file write-back port.
// ALU ops complete in one cycle; MUL (only when ALU_EXEC_MUL_EN is
// defined) runs on mul8_seq and writes back nine cycles after accept.
// Without ALU_EXEC_MUL_EN, op 111 is accepted as a no-op and busy is 0.
module alu_exec
   import alu_exec_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [IDX_W-1:0]  dst,
   input  logic [DATA_W-1:0] R1,
   input  logic [DATA_W-1:0] R2,
   output logic              busy,
   output logic              wd,
   output logic [IDX_W-1:0]  wdpick,
   output logic [DATA_W-1:0] data,
   output logic              zf,
   output logic              cf
);

   state_e            state_r;
   state_e            state_next_s;
   logic              busy_r;
   logic              busy_next_s;
   logic              wd_r;
   logic              wd_next_s;
   logic [IDX_W-1:0]  pick_r;
   logic [IDX_W-1:0]  pick_next_s;
   logic [DATA_W-1:0] data_r;
   logic [DATA_W-1:0] data_next_s;
   logic              zf_r;
   logic              zf_next_s;
   logic              cf_r;
   logic              cf_next_s;
   alu_res_t          alu_s;

   assign alu_s = alu_eval(op_e'(op), R1, R2);

`ifdef ALU_EXEC_MUL_EN
   logic              mul_start_s;
   logic              mul_done_s;
   logic [2:0]        mul_count_s;
   logic [PROD_W-1:0] mul_product_s;
   logic [IDX_W-1:0]  mul_dst_r;

   mul8_seq u_mul (
      .CLK     (CLK),
      .RST     (RST),
      .start   (mul_start_s),
      .a       (R1),
      .b       (R2),
      .count   (mul_count_s),
      .done    (mul_done_s),
      .product (mul_product_s)
   );

   // Latch the destination at accept so later dst changes cannot retarget the multiply
   always_ff @(posedge CLK) begin
      if (RST) begin
         mul_dst_r <= 3'd0;
      end else if (mul_start_s) begin
         mul_dst_r <= dst;
      end
   end
`endif

   // Next-state and write-back decode; outputs hold unless an op writes back
   always_comb begin
      state_next_s = state_r;
      busy_next_s  = busy_r;
      wd_next_s    = 1'b0;
      pick_next_s  = pick_r;
      data_next_s  = data_r;
      zf_next_s    = zf_r;
      cf_next_s    = cf_r;
`ifdef ALU_EXEC_MUL_EN
      mul_start_s  = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (op_e'(op) == OP_MUL) begin
`ifdef ALU_EXEC_MUL_EN
                  mul_start_s  = 1'b1;
                  busy_next_s  = 1'b1;
                  state_next_s = ST_MUL;
`else
                  state_next_s = ST_IDLE;
`endif
               end else begin
                  wd_next_s   = 1'b1;
                  pick_next_s = dst;
                  data_next_s = alu_s.data;
                  cf_next_s   = alu_s.cf;
                  zf_next_s   = (alu_s.data == 8'h00);
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
`ifdef ALU_EXEC_MUL_EN
         ST_MUL: begin
            // leave one cycle early so the final step lands together with write-back
            if (mul_count_s == 3'd6) begin
               state_next_s = ST_WB;
            end else begin
               state_next_s = ST_MUL;
            end
         end
         ST_WB: begin
            if (mul_done_s) begin
               wd_next_s    = 1'b1;
               pick_next_s  = mul_dst_r;
               data_next_s  = mul_product_s[DATA_W-1:0];
               cf_next_s    = (mul_product_s[PROD_W-1:DATA_W] != 8'h00);
               zf_next_s    = (mul_product_s[DATA_W-1:0] == 8'h00);
               busy_next_s  = 1'b0;
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_WB;
            end
         end
`endif
         default: begin
            state_next_s = ST_IDLE;
            busy_next_s  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any multiply and clears the flags
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         wd_r    <= 1'b0;
         pick_r  <= 3'd0;
         data_r  <= 8'h00;
         zf_r    <= 1'b0;
         cf_r    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= busy_next_s;
         wd_r    <= wd_next_s;
         pick_r  <= pick_next_s;
         data_r  <= data_next_s;
         zf_r    <= zf_next_s;
         cf_r    <= cf_next_s;
      end
   end

   assign busy   = busy_r;
   assign wd     = wd_r;
   assign wdpick = pick_r;
   assign data   = data_r;
   assign zf     = zf_r;
   assign cf     = cf_r;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vectors against a behavioural model of alu_exec,
// with literal expectations for the main scenarios. Works with and
// without ALU_EXEC_MUL_EN.
module tb_alu_exec;
   import alu_exec_pkg::*;

`ifdef ALU_EXEC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic       start;
   logic [2:0] op;
   logic [2:0] dst;
   logic [7:0] R1;
   logic [7:0] R2;
   logic       busy;
   logic       wd;
   logic [2:0] wdpick;
   logic [7:0] data;
   logic       zf;
   logic       cf;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // model state
   logic        m_busy, m_wd, m_zf, m_cf;
   logic [2:0]  m_pick, m_dst;
   logic [7:0]  m_data;
   logic [15:0] m_prod;
   int          m_left;

   always #5 CLK = ~CLK;

   alu_exec dut (
      .CLK(CLK), .RST(RST), .start(start), .op(op), .dst(dst),
      .R1(R1), .R2(R2), .busy(busy), .wd(wd), .wdpick(wdpick),
      .data(data), .zf(zf), .cf(cf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_wb(input logic [2:0] d, input logic [7:0] v, input logic c);
      m_wd   = 1'b1;
      m_pick = d;
      m_data = v;
      m_cf   = c;
      m_zf   = (v == 8'h00);
   endtask

   // behavioural model: ALU results from plain integer arithmetic, MUL as a
   // product delivered after a nine-cycle countdown
   always @(posedge CLK) begin : model
      int res;
      if (RST) begin
         m_busy = 1'b0; m_wd = 1'b0; m_pick = 3'd0; m_data = 8'h00;
         m_zf = 1'b0; m_cf = 1'b0; m_left = 0; m_dst = 3'd0; m_prod = 16'h0000;
      end else begin
         m_wd = 1'b0;
         if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_busy = 1'b0;
               model_wb(m_dst, m_prod[7:0], m_prod[15:8] != 8'h00);
            end
         end else if (start) begin
            case (op)
               3'd0: begin res = int'(R1) + int'(R2); model_wb(dst, res[7:0], res > 255); end
               3'd1: begin res = int'(R1) - int'(R2); model_wb(dst, res[7:0], R1 < R2); end
               3'd2: model_wb(dst, R1 & R2, 1'b0);
               3'd3: model_wb(dst, R1 | R2, 1'b0);
               3'd4: model_wb(dst, R1 ^ R2, 1'b0);
               3'd5: begin res = int'(R1) << R2[2:0]; model_wb(dst, res[7:0], 1'b0); end
               3'd6: begin res = int'(R1) >> R2[2:0]; model_wb(dst, res[7:0], 1'b0); end
               default: begin
                  if (MUL_EN) begin
                     m_prod = 16'(R1) * 16'(R2);
                     m_dst  = dst;
                     m_busy = 1'b1;
                     m_left = 8;
                  end
               end
            endcase
         end
      end
   end

   // compare every output against the model on each falling edge
   always @(negedge CLK) begin
      if (chk_en) begin
         check("busy",   32'(busy),   32'(m_busy));
         check("wd",     32'(wd),     32'(m_wd));
         check("wdpick", 32'(wdpick), 32'(m_pick));
         check("data",   32'(data),   32'(m_data));
         check("zf",     32'(zf),     32'(m_zf));
         check("cf",     32'(cf),     32'(m_cf));
      end
   end

   task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
      start = 1'b1; op = o; R1 = a; R2 = b; dst = d;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d, input bit poke,
                          output int busy_cycles, output int wd_cycles, output int wd_at);
      busy_cycles = 0; wd_cycles = 0; wd_at = 0;
      issue(OP_MUL, a, b, d);
      for (int i = 1; i <= 12; i++) begin
         @(negedge CLK);
         if (busy) busy_cycles++;
         if (wd) begin wd_cycles++; wd_at = i; end
         R1 = ~R1; R2 = R2 + 8'd1;
         if (poke && i == 3) begin
            start = 1'b1; op = OP_MUL; R1 = 8'hFF; R2 = 8'hFF; dst = 3'd6;
         end else begin
            start = 1'b0;
         end
      end
   endtask

   initial begin
      int bc, wc, wa, seen;
      RST = 1'b1; start = 1'b1; op = OP_ADD; dst = 3'd7; R1 = 8'h11; R2 = 8'h22;
      @(posedge CLK); #1;
      chk_en = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wd", 32'(wd), 32'd0);
      check("rst_wdpick", 32'(wdpick), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_zf", 32'(zf), 32'd0);
      check("rst_cf", 32'(cf), 32'd0);
      RST = 1'b0; start = 1'b0;

      // ADD with carry
      issue(OP_ADD, 8'hF0, 8'h20, 3'd3);
      @(negedge CLK);
      check("add_wd", 32'(wd), 32'd1);
      check("add_pick", 32'(wdpick), 32'd3);
      check("add_data", 32'(data), 32'h10);
      check("add_cf", 32'(cf), 32'd1);
      check("add_zf", 32'(zf), 32'd0);
      @(negedge CLK);
      check("add_wd_fall", 32'(wd), 32'd0);
      check("add_data_hold", 32'(data), 32'h10);

      // SUB equal and with borrow
      issue(OP_SUB, 8'h05, 8'h05, 3'd0);
      @(negedge CLK);
      check("sub0_data", 32'(data), 32'h00);
      check("sub0_zf", 32'(zf), 32'd1);
      check("sub0_cf", 32'(cf), 32'd0);
      issue(OP_SUB, 8'h03, 8'h05, 3'd4);
      @(negedge CLK);
      check("subb_data", 32'(data), 32'hFE);
      check("subb_cf", 32'(cf), 32'd1);
      check("subb_zf", 32'(zf), 32'd0);

      // back-to-back XOR then SHL (shift amount uses only R2[2:0])
      start = 1'b1; op = OP_XOR; R1 = 8'hAA; R2 = 8'hFF; dst = 3'd1;
      @(posedge CLK); #1;
      op = OP_SHL; R1 = 8'h81; R2 = 8'h0B; dst = 3'd2;
      @(negedge CLK);
      check("b2b1_wd", 32'(wd), 32'd1);
      check("b2b1_pick", 32'(wdpick), 32'd1);
      check("b2b1_data", 32'(data), 32'h55);
      @(posedge CLK); #1;
      start = 1'b0;
      @(negedge CLK);
      check("b2b2_wd", 32'(wd), 32'd1);
      check("b2b2_pick", 32'(wdpick), 32'd2);
      check("b2b2_data", 32'(data), 32'h08);

      // MUL 0x0C x 0x15 with a dropped start while busy and operands wiggling
      run_mul(8'h0C, 8'h15, 3'd5, 1'b1, bc, wc, wa);
      check("mul1_busy_cycles", 32'(bc), MUL_EN ? 32'd8 : 32'd0);
      check("mul1_wd_count", 32'(wc), MUL_EN ? 32'd1 : 32'd0);
      check("mul1_wd_cycle", 32'(wa), MUL_EN ? 32'd9 : 32'd0);
      check("mul1_data", 32'(data), MUL_EN ? 32'hFC : 32'h08);
      check("mul1_pick", 32'(wdpick), MUL_EN ? 32'd5 : 32'd2);
      check("mul1_cf", 32'(cf), 32'd0);

      // MUL with zero low byte and overflow
      run_mul(8'h10, 8'h20, 3'd7, 1'b0, bc, wc, wa);
      check("mul2_wd_cycle", 32'(wa), MUL_EN ? 32'd9 : 32'd0);
      check("mul2_data", 32'(data), MUL_EN ? 32'h00 : 32'h08);
      check("mul2_cf", 32'(cf), MUL_EN ? 32'd1 : 32'd0);
      check("mul2_zf", 32'(zf), MUL_EN ? 32'd1 : 32'd0);

      // reset in the 4th busy cycle aborts the multiply
      issue(OP_MUL, 8'h0C, 8'h15, 3'd4);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("abort_busy_before", 32'(busy), MUL_EN ? 32'd1 : 32'd0);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_wd", 32'(wd), 32'd0);
      check("abort_zf", 32'(zf), 32'd0);
      check("abort_cf", 32'(cf), 32'd0);
      check("abort_data", 32'(data), 32'd0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (wd) seen++;
      end
      check("abort_no_wd", 32'(seen), 32'd0);

      // operations after the abort complete normally
      issue(OP_ADD, 8'h01, 8'h02, 3'd6);
      @(negedge CLK);
      check("post_wd", 32'(wd), 32'd1);
      check("post_pick", 32'(wdpick), 32'd6);
      check("post_data", 32'(data), 32'h03);
      issue(OP_ADD, 8'hFF, 8'h01, 3'd1);
      @(negedge CLK);
      check("wrap_data", 32'(data), 32'h00);
      check("wrap_cf", 32'(cf), 32'd1);
      check("wrap_zf", 32'(zf), 32'd1);
      issue(OP_SHR, 8'h80, 8'h07, 3'd3);
      @(negedge CLK);
      check("shr_data", 32'(data), 32'h01);
      check("shr_cf", 32'(cf), 32'd0);

      @(negedge CLK);
      @(negedge CLK);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
